// File: rtl/bus_if.sv
// ---------------------------------------------------------------------------
// bus_if
//   Bus master interface between a CPU pipeline stage (IF or MEM) and the
//   shared bus. It turns a single-cycle CPU access strobe into a complete bus
//   transaction (request -> grant -> strobe -> ready). It stalls the pipeline
//   through busy until the transaction completes.
//
// Ports
//   clk, reset_          clock; synchronous active-low reset
//   stall, flush         pipeline control from the CPU
//   cpuAddr/cpuAs_/      CPU side of the access:
//   cpuRW/cpuWrData        word address, strobe, read(1)/write(0), write data
//   cpuRdData, busy      read data returned to the CPU; busy = CPU must stall
//   busReq_, busGrnt_    request to the arbiter and grant back from it
//   busAddr/busAs_/      registered master outputs to the bus master mux
//   busRW/busWrData
//   busRdData, busRdy_   read data and ready from the slave mux
// ---------------------------------------------------------------------------
module bus_if #(
   parameter int ADDR_W = 30,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_,
   input  logic              stall,
   input  logic              flush,
   input  logic [ADDR_W-1:0] cpuAddr,
   input  logic              cpuAs_,
   input  logic              cpuRW,
   input  logic [DATA_W-1:0] cpuWrData,
   output logic [DATA_W-1:0] cpuRdData,
   output logic              busy,
   output logic              busReq_,
   input  logic              busGrnt_,
   output logic [ADDR_W-1:0] busAddr,
   output logic              busAs_,
   output logic              busRW,
   output logic [DATA_W-1:0] busWrData,
   input  logic [DATA_W-1:0] busRdData,
   input  logic              busRdy_
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      ACCESS = 2'd2,
      STALL  = 2'd3
   } state_t;

   state_t              state_q,       state_d;
   logic                bus_req_q,     bus_req_d;
   logic                bus_as_q,      bus_as_d;
   logic [ADDR_W-1:0]   bus_addr_q,    bus_addr_d;
   logic                bus_rw_q,      bus_rw_d;
   logic [DATA_W-1:0]   bus_wr_data_q, bus_wr_data_d;
   logic [DATA_W-1:0]   rd_data_q,     rd_data_d;

   logic                busy_c;
   logic [DATA_W-1:0]   cpu_rd_data_c;

   always_comb begin
      state_d       = state_q;
      bus_req_d     = bus_req_q;
      bus_as_d      = bus_as_q;
      bus_addr_d    = bus_addr_q;
      bus_rw_d      = bus_rw_q;
      bus_wr_data_d = bus_wr_data_q;
      rd_data_d     = rd_data_q;
      busy_c        = 1'b0;
      cpu_rd_data_c = rd_data_q;

      case (state_q)
         IDLE: begin
            if (!cpuAs_ && !flush) begin
               busy_c        = 1'b1;
               bus_addr_d    = cpuAddr;
               bus_rw_d      = cpuRW;
               bus_wr_data_d = cpuWrData;
               bus_req_d     = 1'b0;
               state_d       = REQ;
            end
         end

         REQ: begin
            busy_c = 1'b1;
            if (flush) begin
               bus_req_d     = 1'b1;
               bus_addr_d    = '0;
               bus_rw_d      = 1'b1;
               bus_wr_data_d = '0;
               state_d       = IDLE;
            end else if (!busGrnt_) begin
               bus_as_d = 1'b0;
               state_d  = ACCESS;
            end
         end

         ACCESS: begin
            // Strobe is a one-cycle pulse on ACCESS entry; flush is not
            // honoured here because the slave has already seen the access.
            bus_as_d = 1'b1;
            if (busRdy_) begin
               busy_c = 1'b1;
            end else begin
               // Completion: read data goes straight through to the CPU this
               // cycle and is captured so it holds afterwards.
               if (bus_rw_q) begin
                  cpu_rd_data_c = busRdData;
                  rd_data_d     = busRdData;
               end
               bus_req_d     = 1'b1;
               bus_addr_d    = '0;
               bus_rw_d      = 1'b1;
               bus_wr_data_d = '0;
               state_d       = stall ? STALL : IDLE;
            end
         end

         STALL: begin
            // cpuAs_ is still asserted by the stalled stage; ignoring it here
            // stops the same access from being issued twice.
            if (!stall || flush) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_) begin
         state_q       <= IDLE;
         bus_req_q     <= 1'b1;
         bus_as_q      <= 1'b1;
         bus_addr_q    <= '0;
         bus_rw_q      <= 1'b1;
         bus_wr_data_q <= '0;
         rd_data_q     <= '0;
      end else begin
         state_q       <= state_d;
         bus_req_q     <= bus_req_d;
         bus_as_q      <= bus_as_d;
         bus_addr_q    <= bus_addr_d;
         bus_rw_q      <= bus_rw_d;
         bus_wr_data_q <= bus_wr_data_d;
         rd_data_q     <= rd_data_d;
      end
   end

   assign busReq_   = bus_req_q;
   assign busAs_    = bus_as_q;
   assign busAddr   = bus_addr_q;
   assign busRW     = bus_rw_q;
   assign busWrData = bus_wr_data_q;
   assign busy      = busy_c;
   assign cpuRdData = cpu_rd_data_c;

endmodule

// File: tb/tb_bus_if.sv
// ---------------------------------------------------------------------------
// tb_bus_if
//   Directed testbench for bus_if. Inputs change 1 ns after the rising edge;
//   outputs are checked 1 ns later, well clear of the next rising edge.
// ---------------------------------------------------------------------------
module tb_bus_if;

   localparam int ADDR_W = 30;
   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              reset_;
   logic              stall;
   logic              flush;
   logic [ADDR_W-1:0] cpuAddr;
   logic              cpuAs_;
   logic              cpuRW;
   logic [DATA_W-1:0] cpuWrData;
   logic [DATA_W-1:0] cpuRdData;
   logic              busy;
   logic              busReq_;
   logic              busGrnt_;
   logic [ADDR_W-1:0] busAddr;
   logic              busAs_;
   logic              busRW;
   logic [DATA_W-1:0] busWrData;
   logic [DATA_W-1:0] busRdData;
   logic              busRdy_;

   int tests_run    = 0;
   int tests_failed = 0;

   bus_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk       (clk),
      .reset_    (reset_),
      .stall     (stall),
      .flush     (flush),
      .cpuAddr   (cpuAddr),
      .cpuAs_    (cpuAs_),
      .cpuRW     (cpuRW),
      .cpuWrData (cpuWrData),
      .cpuRdData (cpuRdData),
      .busy      (busy),
      .busReq_   (busReq_),
      .busGrnt_  (busGrnt_),
      .busAddr   (busAddr),
      .busAs_    (busAs_),
      .busRW     (busRW),
      .busWrData (busWrData),
      .busRdData (busRdData),
      .busRdy_   (busRdy_)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s = 0x%0h", tag, got);
      end
   endtask

   // Advance to 1 ns after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle after an input change.
   task automatic settle();
      #1;
   endtask

   initial begin
      reset_    = 1'b0;
      stall     = 1'b0;
      flush     = 1'b0;
      cpuAddr   = '0;
      cpuAs_    = 1'b1;
      cpuRW     = 1'b1;
      cpuWrData = '0;
      busGrnt_  = 1'b1;
      busRdData = '0;
      busRdy_   = 1'b1;

      // ---------------- reset state ----------------
      step();
      step();
      settle();
      check_val("rst_busReq_",   64'(busReq_),   64'h1);
      check_val("rst_busAs_",    64'(busAs_),    64'h1);
      check_val("rst_busAddr",   64'(busAddr),   64'h0);
      check_val("rst_busRW",     64'(busRW),     64'h1);
      check_val("rst_busWrData", 64'(busWrData), 64'h0);
      check_val("rst_cpuRdData", 64'(cpuRdData), 64'h0);
      check_val("rst_busy",      64'(busy),      64'h0);
      reset_ = 1'b1;
      step();

      // ---------------- read, zero-wait slave ----------------
      cpuAddr = 30'h0000040;
      cpuRW   = 1'b1;
      cpuAs_  = 1'b0;
      settle();
      check_val("rd_idle_busy", 64'(busy), 64'h1);
      step();                       // REQ, no grant yet
      cpuAs_ = 1'b1;
      settle();
      check_val("rd_req_busReq_", 64'(busReq_), 64'h0);
      check_val("rd_req_busAs_",  64'(busAs_),  64'h1);
      check_val("rd_req_busAddr", 64'(busAddr), 64'h40);
      check_val("rd_req_busy",    64'(busy),    64'h1);
      step();                       // REQ, grant now
      busGrnt_ = 1'b0;
      settle();
      check_val("rd_grant_busAs_", 64'(busAs_), 64'h1);
      step();                       // first ACCESS cycle, slave ready
      busGrnt_  = 1'b1;
      busRdy_   = 1'b0;
      busRdData = 32'hDEADBEEF;
      settle();
      check_val("rd_acc_busAs_",    64'(busAs_),    64'h0);
      check_val("rd_done_busy",     64'(busy),      64'h0);
      check_val("rd_done_cpuRdData",64'(cpuRdData), 64'hDEADBEEF);
      step();                       // back in IDLE
      busRdy_   = 1'b1;
      busRdData = 32'h0;
      settle();
      check_val("rd_post_busAs_",    64'(busAs_),    64'h1);
      check_val("rd_post_busReq_",   64'(busReq_),   64'h1);
      check_val("rd_post_cpuRdData", 64'(cpuRdData), 64'hDEADBEEF);
      check_val("rd_post_busAddr",   64'(busAddr),   64'h0);
      check_val("rd_post_busy",      64'(busy),      64'h0);

      // ---------------- write, 3 wait cycles ----------------
      cpuAddr   = 30'h0000100;
      cpuRW     = 1'b0;
      cpuWrData = 32'h12345678;
      cpuAs_    = 1'b0;
      step();                       // REQ
      cpuAs_   = 1'b1;
      busGrnt_ = 1'b0;
      step();                       // ACCESS
      busGrnt_ = 1'b1;
      for (int i = 0; i < 3; i++) begin
         settle();
         check_val($sformatf("wr_wait%0d_busAs_", i),    64'(busAs_),    (i == 0) ? 64'h0 : 64'h1);
         check_val($sformatf("wr_wait%0d_busRW", i),     64'(busRW),     64'h0);
         check_val($sformatf("wr_wait%0d_busWrData", i), 64'(busWrData), 64'h12345678);
         check_val($sformatf("wr_wait%0d_busAddr", i),   64'(busAddr),   64'h100);
         check_val($sformatf("wr_wait%0d_busy", i),      64'(busy),      64'h1);
         step();
      end
      busRdy_   = 1'b0;
      busRdData = 32'hCAFEF00D;
      settle();
      check_val("wr_done_busy",      64'(busy),      64'h0);
      check_val("wr_done_busRW",     64'(busRW),     64'h0);
      check_val("wr_done_busWrData", 64'(busWrData), 64'h12345678);
      check_val("wr_done_cpuRdData", 64'(cpuRdData), 64'hDEADBEEF);
      step();
      busRdy_   = 1'b1;
      busRdData = 32'h0;
      settle();
      check_val("wr_post_busReq_",   64'(busReq_),   64'h1);
      check_val("wr_post_cpuRdData", 64'(cpuRdData), 64'hDEADBEEF);
      check_val("wr_post_busRW",     64'(busRW),     64'h1);
      check_val("wr_post_busWrData", 64'(busWrData), 64'h0);

      // ---------------- stall past completion ----------------
      cpuAddr = 30'h0000200;
      cpuRW   = 1'b1;
      cpuAs_  = 1'b0;               // held low throughout
      step();                       // REQ
      busGrnt_ = 1'b0;
      step();                       // ACCESS, zero wait, stall raised
      busGrnt_  = 1'b1;
      busRdy_   = 1'b0;
      busRdData = 32'h0BADF00D;
      stall     = 1'b1;
      settle();
      check_val("st_done_busy",      64'(busy),      64'h0);
      check_val("st_done_cpuRdData", 64'(cpuRdData), 64'h0BADF00D);
      step();                       // STALL cycle 1
      busRdy_   = 1'b1;
      busRdData = 32'h0;
      settle();
      check_val("st_s1_busy",    64'(busy),    64'h0);
      check_val("st_s1_busReq_", 64'(busReq_), 64'h1);
      step();                       // STALL cycle 2
      settle();
      check_val("st_s2_busy",      64'(busy),      64'h0);
      check_val("st_s2_busReq_",   64'(busReq_),   64'h1);
      check_val("st_s2_cpuRdData", 64'(cpuRdData), 64'h0BADF00D);
      stall = 1'b0;
      settle();
      check_val("st_drop_busy", 64'(busy), 64'h0);
      step();                       // IDLE; cpuAs_ still low -> new access
      settle();
      check_val("st_idle_busy", 64'(busy), 64'h1);

      // ---------------- flush while in REQ ----------------
      step();                       // REQ for address 0x200
      cpuAs_ = 1'b1;
      settle();
      check_val("fl_req_busReq_", 64'(busReq_), 64'h0);
      check_val("fl_req_busAddr", 64'(busAddr), 64'h200);
      flush = 1'b1;
      settle();
      check_val("fl_req_busy", 64'(busy), 64'h1);
      step();                       // IDLE after flush
      flush = 1'b0;
      settle();
      check_val("fl_post_busReq_", 64'(busReq_), 64'h1);
      check_val("fl_post_busAs_",  64'(busAs_),  64'h1);
      check_val("fl_post_busAddr", 64'(busAddr), 64'h0);
      check_val("fl_post_busy",    64'(busy),    64'h0);
      step();
      settle();
      check_val("fl_post2_busAs_",  64'(busAs_),  64'h1);
      check_val("fl_post2_busReq_", 64'(busReq_), 64'h1);

      // ---------------- grant withheld 10 cycles ----------------
      cpuAddr = 30'h0000300;
      cpuRW   = 1'b1;
      cpuAs_  = 1'b0;
      step();                       // REQ
      cpuAs_ = 1'b1;
      for (int i = 0; i < 10; i++) begin
         settle();
         check_val($sformatf("gw%0d_busy", i),    64'(busy),    64'h1);
         check_val($sformatf("gw%0d_busReq_", i), 64'(busReq_), 64'h0);
         check_val($sformatf("gw%0d_busAs_", i),  64'(busAs_),  64'h1);
         step();
      end
      busGrnt_ = 1'b0;
      settle();
      check_val("gw_grant_busAs_", 64'(busAs_), 64'h1);
      step();                       // ACCESS one edge after grant
      busGrnt_ = 1'b1;
      settle();
      check_val("gw_acc_busAs_", 64'(busAs_), 64'h0);
      check_val("gw_acc_busy",   64'(busy),   64'h1);

      // ---------------- reset during ACCESS wait ----------------
      step();                       // ACCESS wait, strobe released
      settle();
      check_val("rw_wait_busAs_", 64'(busAs_), 64'h1);
      check_val("rw_wait_busy",   64'(busy),   64'h1);
      reset_ = 1'b0;
      step();
      settle();
      check_val("rw_rst_busReq_",   64'(busReq_),   64'h1);
      check_val("rw_rst_busAs_",    64'(busAs_),    64'h1);
      check_val("rw_rst_busAddr",   64'(busAddr),   64'h0);
      check_val("rw_rst_busy",      64'(busy),      64'h0);
      check_val("rw_rst_cpuRdData", 64'(cpuRdData), 64'h0);
      reset_ = 1'b1;
      step();
      settle();
      check_val("rw_after_busReq_", 64'(busReq_), 64'h1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
